vga_timing_gen: RTL and testbench

// - Source end of vga_if: drives vga_if.out with hcount/vcount, hsync/vsync, hblnk/vblnk.
// - Sits directly after the pixel clock; all draw stages consume its vga_if.in downstream.
// - Parameterised raster timing; default 800x600@60 (40 MHz pixel clock), positive syncs.

---
 rtl/vga_pkg.sv | 19 +
 rtl/vga_if.sv | 13 +
 rtl/vga_axis_counter.sv | 57 +++++
 rtl/vga_timing_gen.sv | 62 ++++++
 tb/tb_vga_timing_gen.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared raster timing defaults and helpers for the VGA pipeline.
package vga_pkg;
  localparam int COUNT_W  = 11;
  localparam int H_ACTIVE = 800;
  localparam int H_FP     = 40;
  localparam int H_SYNC   = 128;
  localparam int H_BP     = 88;
  localparam int V_ACTIVE = 600;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 4;
  localparam int V_BP     = 23;

  function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
endpackage

// File: rtl/vga_if.sv
// Raster position and timing flags passed from the timing generator to draw stages.
interface vga_if;
  import vga_pkg::*;
  logic [COUNT_W-1:0] hcount;
  logic [COUNT_W-1:0] vcount;
  logic               hsync;
  logic               vsync;
  logic               hblnk;
  logic               vblnk;

  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk);
  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk);
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrap counter plus blank/sync flags registered from the next count.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int   W        = COUNT_W,
  parameter int   ACTIVE   = 800,
  parameter int   FP       = 40,
  parameter int   SYNC     = 128,
  parameter int   BP       = 88,
  parameter logic SYNC_POL = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o,
  output logic         blnk_o,
  output logic         sync_o
);
  localparam int         TOTAL   = axis_total(ACTIVE, FP, SYNC, BP);
  localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
  localparam logic [W-1:0] BLNK_LO = W'(ACTIVE);
  localparam logic [W-1:0] SYNC_LO = W'(ACTIVE + FP);
  localparam logic [W-1:0] SYNC_HI = W'(ACTIVE + FP + SYNC);

  logic [W-1:0] cnt_q, cnt_d;
  logic         blnk_q, blnk_d;
  logic         sync_q, sync_d;
  logic         last;

  assign last   = (cnt_q == LAST);
  assign wrap_o = inc_i & last;

  // Flags decode the value the counter is about to take, so they line up with it.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i) cnt_d = last ? '0 : cnt_q + W'(1);
    blnk_d = (cnt_d >= BLNK_LO);
    sync_d = (cnt_d >= SYNC_LO && cnt_d < SYNC_HI) ? SYNC_POL : ~SYNC_POL;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      blnk_q <= 1'b0;
      sync_q <= ~SYNC_POL;
    end else begin
      cnt_q  <= cnt_d;
      blnk_q <= blnk_d;
      sync_q <= sync_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign blnk_o = blnk_q;
  assign sync_o = sync_q;
endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source: H/V axis counters driving vga_if plus a frame-start pulse.
module vga_timing_gen #(
  parameter int   H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int   H_FP     = vga_pkg::H_FP,
  parameter int   H_SYNC   = vga_pkg::H_SYNC,
  parameter int   H_BP     = vga_pkg::H_BP,
  parameter int   V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int   V_FP     = vga_pkg::V_FP,
  parameter int   V_SYNC   = vga_pkg::V_SYNC,
  parameter int   V_BP     = vga_pkg::V_BP,
  parameter logic SYNC_POL = 1'b1
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  ce,
  vga_if.out    vga_out,
  output logic  frame_start
);
  import vga_pkg::*;

  localparam int HT = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int VT = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (HT > 2048 || VT > 2048 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_timing
    $fatal(1, "vga_timing_gen: illegal raster timing parameters");
  end

  logic [COUNT_W-1:0] h_cnt, v_cnt;
  logic h_wrap, v_wrap, h_blnk, v_blnk, h_sync, v_sync;
  logic frame_start_q, frame_start_d;

  vga_axis_counter #(
    .W(COUNT_W), .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .SYNC_POL(SYNC_POL)
  ) u_h (
    .clk_i(clk), .rst_i(rst), .inc_i(ce),
    .cnt_o(h_cnt), .wrap_o(h_wrap), .blnk_o(h_blnk), .sync_o(h_sync)
  );

  vga_axis_counter #(
    .W(COUNT_W), .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .SYNC_POL(SYNC_POL)
  ) u_v (
    .clk_i(clk), .rst_i(rst), .inc_i(ce & h_wrap),
    .cnt_o(v_cnt), .wrap_o(v_wrap), .blnk_o(v_blnk), .sync_o(v_sync)
  );

  // v_wrap already implies ce and a line wrap: the counts go to (0,0) on this edge.
  assign frame_start_d = v_wrap;

  always_ff @(posedge clk) begin
    if (rst) frame_start_q <= 1'b0;
    else     frame_start_q <= frame_start_d;
  end

  assign vga_out.hcount = h_cnt;
  assign vga_out.vcount = v_cnt;
  assign vga_out.hsync  = h_sync;
  assign vga_out.vsync  = v_sync;
  assign vga_out.hblnk  = h_blnk;
  assign vga_out.vblnk  = v_blnk;
  assign frame_start    = frame_start_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 800x600 instance (line timing) and a tiny-raster instance (frames).
module tb_vga_timing_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, ce_a, rst_b, ce_b, fs_a, fs_b;
  vga_if vif_a();
  vga_if vif_b();

  vga_timing_gen dut_a (.clk(clk), .rst(rst_a), .ce(ce_a), .vga_out(vif_a), .frame_start(fs_a));

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b0)
  ) dut_b (.clk(clk), .rst(rst_b), .ce(ce_b), .vga_out(vif_b), .frame_start(fs_b));

  int checks = 0;
  int errors = 0;
  int prints = 0;

  int   HA [2] = '{800, 4};
  int   HF [2] = '{40, 1};
  int   HS [2] = '{128, 2};
  int   HB [2] = '{88, 1};
  int   VA [2] = '{600, 3};
  int   VF [2] = '{1, 1};
  int   VS [2] = '{4, 1};
  int   VB [2] = '{23, 1};
  logic POL[2] = '{1'b1, 1'b0};

  // Model state: raster position as a linear pixel index within the frame.
  int   p    [2];
  logic fs_m [2];
  bit   valid[2];

  logic [25:0] act    [2];
  logic        fs_act [2];
  assign act[0] = {vif_a.hcount, vif_a.vcount, vif_a.hsync, vif_a.vsync, vif_a.hblnk, vif_a.vblnk};
  assign act[1] = {vif_b.hcount, vif_b.vcount, vif_b.hsync, vif_b.vsync, vif_b.hblnk, vif_b.vblnk};
  assign fs_act[0] = fs_a;
  assign fs_act[1] = fs_b;

  function automatic int ht(input int i);
    return HA[i] + HF[i] + HS[i] + HB[i];
  endfunction

  function automatic int vt(input int i);
    return VA[i] + VF[i] + VS[i] + VB[i];
  endfunction

  function automatic logic [25:0] expv(input int i, input int pp);
    int h, v;
    logic hs, vs;
    h  = pp % ht(i);
    v  = (pp / ht(i)) % vt(i);
    hs = (h >= HA[i] + HF[i] && h < HA[i] + HF[i] + HS[i]) ? POL[i] : ~POL[i];
    vs = (v >= VA[i] + VF[i] && v < VA[i] + VF[i] + VS[i]) ? POL[i] : ~POL[i];
    return {11'(h), 11'(v), hs, vs, (h >= HA[i]), (v >= VA[i])};
  endfunction

  task automatic mdl(input int i, input logic r, input logic c);
    if (r) begin
      p[i] = 0; fs_m[i] = 1'b0; valid[i] = 1'b1;
    end else if (c) begin
      p[i] = (p[i] + 1) % (ht(i) * vt(i));
      fs_m[i] = (p[i] == 0);
    end else begin
      fs_m[i] = 1'b0;
    end
  endtask

  always @(posedge clk) begin
    mdl(0, rst_a, ce_a);
    mdl(1, rst_b, ce_b);
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (valid[i]) begin
        checks++;
        if (act[i] !== expv(i, p[i]) || fs_act[i] !== fs_m[i]) begin
          errors++;
          if (prints < 10)
            $display("FAIL model[%0d] p=%0d: got %h fs=%b, expected %h fs=%b",
                     i, p[i], act[i], fs_act[i], expv(i, p[i]), fs_m[i]);
          prints++;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, a, e);
    end
  endtask

  initial begin
    int hs_high, hb_rise, wraps, fs_cnt, fs_a_cnt, last_fs, bad_int, stable_bad, gap;
    logic [10:0] ph, pv;
    logic pb, found;
    logic [7:0] hmask;
    logic [5:0] vmask;
    logic [25:0] prev_act;

    rst_a = 1'b1; rst_b = 1'b1; ce_a = 1'b1; ce_b = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_hcount_a", vif_a.hcount, 0);
    chk("rst_vcount_a", vif_a.vcount, 0);
    chk("rst_hblnk_a",  vif_a.hblnk, 0);
    chk("rst_vblnk_a",  vif_a.vblnk, 0);
    chk("rst_hsync_a",  vif_a.hsync, 0);
    chk("rst_vsync_a",  vif_a.vsync, 0);
    chk("rst_fs_a",     fs_a, 0);
    chk("rst_hsync_b",  vif_b.hsync, 1);
    chk("rst_vsync_b",  vif_b.vsync, 1);
    chk("rst_fs_b",     fs_b, 0);
    rst_a = 1'b0; rst_b = 1'b0;

    // Full-rate run: three default lines, many tiny frames.
    hs_high = 0; hb_rise = -1; wraps = 0; fs_cnt = 0; fs_a_cnt = 0; last_fs = -1; bad_int = 0;
    hmask = '0; vmask = '0;
    ph = vif_a.hcount; pv = vif_a.vcount; pb = vif_a.hblnk;
    for (int c = 0; c < 3 * 1056 + 10; c++) begin
      @(negedge clk);
      if (vif_a.vcount == 0 && vif_a.hsync) hs_high++;
      if (!pb && vif_a.hblnk && hb_rise < 0) hb_rise = int'(vif_a.hcount);
      if (ph == 11'd1055 && vif_a.hcount == 11'd0 && vif_a.vcount == pv + 11'd1) wraps++;
      ph = vif_a.hcount; pv = vif_a.vcount; pb = vif_a.hblnk;
      if (fs_a) fs_a_cnt++;
      if (fs_b) begin
        if (last_fs >= 0 && c - last_fs != 48) bad_int++;
        last_fs = c; fs_cnt++;
      end
      if (!vif_b.hsync) hmask[vif_b.hcount[2:0]] = 1'b1;
      if (!vif_b.vsync) vmask[vif_b.vcount[2:0]] = 1'b1;
    end
    chk("hsync_high_cycles", hs_high, 128);
    chk("hblnk_rise_hcount", hb_rise, 800);
    chk("line_wraps",        wraps, 3);
    chk("fs_a_none",         fs_a_cnt, 0);
    chk("fs_b_count",        fs_cnt, 66);
    chk("fs_b_period48",     bad_int, 0);
    chk("hsync_low_mask_b",  hmask, 8'h60);
    chk("vsync_low_mask_b",  vmask, 6'h10);

    // Half-rate pixel enable.
    fs_cnt = 0; last_fs = -1; bad_int = 0; stable_bad = 0; prev_act = act[1];
    for (int c = 0; c < 401; c++) begin
      @(negedge clk);
      if (!ce_b && act[1] !== prev_act) stable_bad++;
      prev_act = act[1];
      if (fs_b) begin
        if (last_fs >= 0 && c - last_fs != 96) bad_int++;
        last_fs = c; fs_cnt++;
      end
      ce_b = ~ce_b;
    end
    ce_b = 1'b1;
    chk("ce_hold_stable", stable_bad, 0);
    chk("ce_fs_period96", bad_int, 0);
    chk("ce_fs_seen",     fs_cnt >= 4, 1);

    // Mid-frame reset on the tiny raster, with ce high (reset wins).
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      if (vif_b.hcount == 5 && vif_b.vcount == 3) found = 1'b1;
    end
    chk("find_b_5_3", found, 1);
    rst_b = 1'b1;
    @(negedge clk);
    chk("midrst_hcount_b", vif_b.hcount, 0);
    chk("midrst_vcount_b", vif_b.vcount, 0);
    chk("midrst_fs_b",     fs_b, 0);
    chk("midrst_hsync_b",  vif_b.hsync, 1);
    chk("midrst_vblnk_b",  vif_b.vblnk, 0);
    rst_b = 1'b0;
    gap = 0;
    for (int c = 1; c <= 100 && gap == 0; c++) begin
      @(negedge clk);
      if (fs_b) gap = c;
    end
    chk("midrst_fs_gap_b", gap, 48);

    // Reset on the default raster at hcount=500 while ce is low.
    found = 1'b0;
    for (int c = 0; c < 1100 && !found; c++) begin
      @(negedge clk);
      if (vif_a.hcount == 500) found = 1'b1;
    end
    chk("find_a_500", found, 1);
    chk("pre_rst_vcount_a", vif_a.vcount, 3);
    ce_a = 1'b0; rst_a = 1'b1;
    @(negedge clk);
    chk("midrst_hcount_a", vif_a.hcount, 0);
    chk("midrst_vcount_a", vif_a.vcount, 0);
    chk("midrst_fs_a",     fs_a, 0);
    rst_a = 1'b0; ce_a = 1'b1;
    @(negedge clk);
    chk("resume_hcount_a", vif_a.hcount, 1);
    repeat (1100) @(negedge clk);
    chk("resume_vcount_a", vif_a.vcount, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
